// File: rtl/multiplier_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
// Optional feature macro: MULTIPLIER_SINGLE_CYCLE_STEP_EN (selects the merged STEP state).
package multiplier_pkg;

  localparam int MULTIPLIER_DEFAULT_WIDTH = 4;

  // STEP is only reachable when MULTIPLIER_SINGLE_CYCLE_STEP_EN is defined.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4,
    STEP  = 3'd5
  } multiplier_state_t;

endpackage

// File: rtl/multiplier_controller.sv
// Sequencing FSM for the shift-add multiplier: handshakes, datapath strobes, completion.
// Define MULTIPLIER_SINGLE_CYCLE_STEP_EN to merge ADD and SHIFT into one STEP state.
module multiplier_controller
  import multiplier_pkg::*;
#(
  parameter int N = MULTIPLIER_DEFAULT_WIDTH
) (
  input  logic clock,
  input  logic n_reset,
  input  logic start_valid,
  output logic start_ready,
  input  logic abort,
  input  logic multiplier_lsb,
  input  logic is_zero,
  output logic do_load,
  output logic do_preset,
  output logic do_add,
  output logic do_shift,
  output logic do_decrement,
  output logic busy,
  output logic result_valid,
  input  logic result_ready
);

  // The iteration count lives in the external counter; N only bounds legal widths here.
  generate
    if (N < 32'sd2) begin : g_width_check
      $error("multiplier_controller: N must be at least 2");
    end
  endgenerate

  multiplier_state_t state_r;
  multiplier_state_t next_state_s;

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and strobe decode; abort outside IDLE forces IDLE with all strobes low.
  always_comb begin
    next_state_s = state_r;
    do_load      = 1'b0;
    do_preset    = 1'b0;
    do_add       = 1'b0;
    do_shift     = 1'b0;
    do_decrement = 1'b0;
    if (state_r == IDLE) begin
      if (start_valid) begin
        next_state_s = LOAD;
      end else begin
        next_state_s = IDLE;
      end
    end else if (abort) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        LOAD: begin
          do_load   = 1'b1;
          do_preset = 1'b1;
`ifdef MULTIPLIER_SINGLE_CYCLE_STEP_EN
          next_state_s = STEP;
`else
          next_state_s = ADD;
`endif
        end
`ifdef MULTIPLIER_SINGLE_CYCLE_STEP_EN
        STEP: begin
          do_add       = multiplier_lsb;
          do_shift     = 1'b1;
          do_decrement = ~is_zero;
          if (is_zero) begin
            next_state_s = DONE;
          end else begin
            next_state_s = STEP;
          end
        end
`else
        ADD: begin
          do_add       = multiplier_lsb;
          next_state_s = SHIFT;
        end
        SHIFT: begin
          do_shift = 1'b1;
          // The last shift happens with the counter already at zero, giving N iterations.
          if (is_zero) begin
            next_state_s = DONE;
          end else begin
            do_decrement = 1'b1;
            next_state_s = ADD;
          end
        end
`endif
        DONE: begin
          if (result_ready) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = DONE;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

  // Handshake and status flags decode from state alone.
  always_comb begin
    start_ready  = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state_r)
      IDLE: begin
        start_ready = 1'b1;
      end
      LOAD, ADD, SHIFT, STEP: begin
        busy = 1'b1;
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
